// File: rtl/noc_credit_link_stage.sv
// Registered credit-based link stage: local FIFO, downstream credit tracking, upstream credit return.
// Optional per-link flit/packet statistics are compiled in with NOC_LINK_STATS_EN.
module noc_credit_link_stage #(
    parameter int FLIT_WIDTH         = 64,
    parameter int DEST_WIDTH         = 4,
    parameter int BUFFER_DEPTH       = 4,
    parameter int DOWNSTREAM_CREDITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
`ifdef NOC_LINK_STATS_EN
    output logic [31:0]           flit_count,
    output logic [31:0]           pkt_count,
`endif
    output logic                  overflow_err
);

    // Link protocol: send_* qualifies a flit for exactly one cycle with no back-pressure;
    // flow control is purely by credits, one credit pulse per freed receiver slot.
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DOWNSTREAM_CREDITS + 1);
    localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DOWNSTREAM_CREDITS);

    logic [EW-1:0] mem [BUFFER_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] credit_cnt;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = !empty && (credit_cnt != '0);
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign push  = send_in && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {is_tail_in, dest_in, data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CRED_MAX;
        end else begin
            case ({credit_in, pop})
                2'b10: begin
                    if (credit_cnt != CRED_MAX) begin
                        credit_cnt <= credit_cnt + CW'(1);
                    end
                end
                2'b01:   credit_cnt <= credit_cnt - CW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            credit_out  <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
        end else begin
            send_out   <= pop;
            credit_out <= pop;
            if (pop) begin
                {is_tail_out, dest_out, data_out} <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (send_in && !push) begin
            overflow_err <= 1'b1;
        end
    end

`ifdef NOC_LINK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_count <= '0;
            pkt_count  <= '0;
        end else if (pop) begin
            flit_count <= flit_count + 32'd1;
            if (mem[rd_ptr[AW-1:0]][EW-1]) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule
